// File: rtl/ul_ram_pkg.sv
// Shared constants, state encoding and helpers for the uplink ping-pong RAM
// (write controller and read controller).
package ul_ram_pkg;

  // Frame geometry: two sync bytes plus 260 payload bytes
  localparam logic [8:0]  FRAME_LEN = 9'd262;

  // Ping-pong buffer windows inside the 1K uplink RAM
  localparam logic [9:0]  RAM0_BASE = 10'd0;
  localparam logic [9:0]  RAM0_END  = 10'd261;
  localparam logic [9:0]  RAM1_BASE = 10'd512;
  localparam logic [9:0]  RAM1_END  = 10'd773;

  // Two-byte frame sync word
  localparam logic [7:0]  SYNC0 = 8'hEB;
  localparam logic [7:0]  SYNC1 = 8'h90;

  // Idle cycles tolerated inside a frame before it is abandoned
  localparam logic [12:0] TIMEOUT = 13'd4096;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_HDR   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_DROP  = 3'd4
  } ul_state_e;

  // Start address of the buffer selected by sel
  function automatic logic [9:0] ram_base(input logic sel);
    return sel ? RAM1_BASE : RAM0_BASE;
  endfunction

endpackage

// File: rtl/ul_sync_detect.sv
// Sync-word detector: remembers the previous hunted byte and flags the
// cycle in which SYNC0 followed by SYNC1 has been received.
module ul_sync_detect
  import ul_ram_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       i_capture,
  input  logic       i_clear,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_sync_hit
);

  logic [7:0] r_prev_byte;

  // Previous byte is only tracked while hunting; cleared when a frame ends
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_prev_byte <= 8'h00;
    end else if (i_clear) begin
      r_prev_byte <= 8'h00;
    end else if (i_capture && i_rx_valid) begin
      r_prev_byte <= i_rx_data;
    end
  end

  assign o_sync_hit = i_capture & i_rx_valid &
                      (i_rx_data == SYNC1) & (r_prev_byte == SYNC0);

endmodule

// File: rtl/ul_wr_ram_control.sv
// Uplink write-side controller: hunts the sync word, writes each frame into
// the free half of the ping-pong RAM and flags full buffers to the reader.
// Buffer flag handshake: UlRAM_wr_state[i] is set when buffer i holds a
// complete frame and is cleared while the reader holds UlRAM_rd_state[i].
// Optional feature: define UL_WR_OVF_CNT_EN to add the ovf_count port,
// a saturating count of discarded frames.
module ul_wr_ram_control
  import ul_ram_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        UlDataRevEnable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [1:0]  UlRAM_rd_state,
  output logic [1:0]  UlRAM_wr_state,
  output logic        wrRAMEn,
  output logic [9:0]  wrRAMAddr,
  output logic [7:0]  wrRAMData,
  output logic        frame_drop,
  output logic [2:0]  dbg_state
`ifdef UL_WR_OVF_CNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  ul_state_e   r_state,      w_state;
  logic        r_wr_sel,     w_wr_sel;
  logic [8:0]  r_byte_cnt,   w_byte_cnt;
  logic [12:0] r_idle_cnt,   w_idle_cnt;
  logic [1:0]  r_wr_state,   w_wr_state;
  logic        r_wr_en,      w_wr_en;
  logic [9:0]  r_wr_addr,    w_wr_addr;
  logic [7:0]  r_wr_data,    w_wr_data;
  logic        r_frame_drop, w_drop;
  logic        w_clr_prev;
  logic        w_sync_hit;
  logic        w_capture;
  logic [9:0]  w_base;
  logic [12:0] w_idle_inc;

  assign w_capture  = (r_state == S_HUNT) && UlDataRevEnable;
  assign w_base     = ram_base(r_wr_sel);
  assign w_idle_inc = r_idle_cnt + 13'd1;

  ul_sync_detect u_sync_detect (
    .clk        (clk),
    .nRst       (nRst),
    .i_capture  (w_capture),
    .i_clear    (w_clr_prev),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_sync_hit (w_sync_hit)
  );

  // Next-state, RAM write and buffer-flag decisions
  always_comb begin
    w_state    = r_state;
    w_wr_sel   = r_wr_sel;
    w_byte_cnt = r_byte_cnt;
    w_idle_cnt = r_idle_cnt;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;
    w_drop     = 1'b0;
    w_clr_prev = 1'b0;
    // Reader release is level-based; a set in S_DONE below overrides it
    w_wr_state = r_wr_state & ~UlRAM_rd_state;

    case (r_state)
      S_HUNT: begin
        if (w_sync_hit) begin
          w_byte_cnt = 9'd2;
          w_idle_cnt = 13'd0;
          if (!r_wr_state[r_wr_sel]) begin
            // SYNC1 goes out now; SYNC0 follows in the gap before payload
            w_wr_en   = 1'b1;
            w_wr_addr = w_base + 10'd1;
            w_wr_data = SYNC1;
            w_state   = S_HDR;
          end else begin
            w_drop  = 1'b1;
            w_state = S_DROP;
          end
        end
      end
      S_HDR: begin
        w_wr_en    = 1'b1;
        w_wr_addr  = w_base;
        w_wr_data  = SYNC0;
        w_idle_cnt = 13'd0;
        w_state    = S_WRITE;
      end
      S_WRITE: begin
        if (rx_valid) begin
          w_wr_en    = 1'b1;
          w_wr_addr  = w_base + {1'b0, r_byte_cnt};
          w_wr_data  = rx_data;
          w_byte_cnt = r_byte_cnt + 9'd1;
          w_idle_cnt = 13'd0;
          if (r_byte_cnt == FRAME_LEN - 9'd1) w_state = S_DONE;
        end else begin
          w_idle_cnt = w_idle_inc;
          if (w_idle_inc == TIMEOUT) begin
            w_drop     = 1'b1;
            w_state    = S_HUNT;
            w_byte_cnt = 9'd0;
            w_idle_cnt = 13'd0;
            w_clr_prev = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_wr_state[r_wr_sel] = 1'b1;
        w_wr_sel   = ~r_wr_sel;
        w_byte_cnt = 9'd0;
        w_clr_prev = 1'b1;
        w_state    = S_HUNT;
      end
      S_DROP: begin
        if (rx_valid) begin
          w_byte_cnt = r_byte_cnt + 9'd1;
          w_idle_cnt = 13'd0;
          if (r_byte_cnt + 9'd1 == FRAME_LEN) begin
            w_byte_cnt = 9'd0;
            w_state    = S_HUNT;
          end
        end else begin
          w_idle_cnt = w_idle_inc;
          if (w_idle_inc == TIMEOUT) begin
            w_byte_cnt = 9'd0;
            w_idle_cnt = 13'd0;
            w_clr_prev = 1'b1;
            w_state    = S_HUNT;
          end
        end
      end
      default: w_state = S_HUNT;
    endcase

    // Link down flushes everything, abandoning any partial frame silently
    if (!UlDataRevEnable) begin
      w_state    = S_HUNT;
      w_wr_sel   = 1'b0;
      w_byte_cnt = 9'd0;
      w_idle_cnt = 13'd0;
      w_wr_state = 2'b00;
      w_wr_en    = 1'b0;
      w_drop     = 1'b0;
      w_clr_prev = 1'b1;
    end
  end

  // State and registered RAM-side outputs
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= S_HUNT;
      r_wr_sel     <= 1'b0;
      r_byte_cnt   <= 9'd0;
      r_idle_cnt   <= 13'd0;
      r_wr_state   <= 2'b00;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 10'd0;
      r_wr_data    <= 8'd0;
      r_frame_drop <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_wr_sel     <= w_wr_sel;
      r_byte_cnt   <= w_byte_cnt;
      r_idle_cnt   <= w_idle_cnt;
      r_wr_state   <= w_wr_state;
      r_wr_en      <= w_wr_en;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_frame_drop <= w_drop;
    end
  end

  assign UlRAM_wr_state = r_wr_state;
  assign wrRAMEn        = r_wr_en;
  assign wrRAMAddr      = r_wr_addr;
  assign wrRAMData      = r_wr_data;
  assign frame_drop     = r_frame_drop;
  assign dbg_state      = r_state;

`ifdef UL_WR_OVF_CNT_EN
  logic [15:0] r_ovf_count;

  // Saturating count of discarded frames, cleared when the link drops
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_ovf_count <= 16'd0;
    end else if (!UlDataRevEnable) begin
      r_ovf_count <= 16'd0;
    end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
      r_ovf_count <= r_ovf_count + 16'd1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_ul_wr_ram_control.sv
// Bench for ul_wr_ram_control: a frame-level model predicts every RAM write
// and the buffer flags; literal checks pin key addresses and timings.
module tb_ul_wr_ram_control;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        nRst;
  logic        UlDataRevEnable;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  UlRAM_rd_state;
  logic [1:0]  UlRAM_wr_state;
  logic        wrRAMEn;
  logic [9:0]  wrRAMAddr;
  logic [7:0]  wrRAMData;
  logic        frame_drop;
  logic [2:0]  dbg_state;
`ifdef UL_WR_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  always #5 clk = ~clk;

  ul_wr_ram_control dut (
    .clk             (clk),
    .nRst            (nRst),
    .UlDataRevEnable (UlDataRevEnable),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .UlRAM_rd_state  (UlRAM_rd_state),
    .UlRAM_wr_state  (UlRAM_wr_state),
    .wrRAMEn         (wrRAMEn),
    .wrRAMAddr       (wrRAMAddr),
    .wrRAMData       (wrRAMData),
    .frame_drop      (frame_drop),
    .dbg_state       (dbg_state)
`ifdef UL_WR_OVF_CNT_EN
    ,
    .ovf_count       (ovf_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] exp_q[$];          // expected {addr, data} writes, in order
  logic [7:0]  dut_ram[1024];     // what the DUT actually wrote
  int          drop_seen  = 0;
  int          exp_drops  = 0;
  logic        m_sel      = 1'b0; // model: buffer the next frame goes to
  logic [1:0]  m_full     = 2'b00;// model: buffer full flags
  logic        last_sync_drop;
  logic        last_sync_wen;
  logic [9:0]  last_sync_addr;
  logic [7:0]  last_sync_data;
  logic [17:0] cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Payload byte for frame index k (2..261) of a frame built with seed
  function automatic logic [7:0] pbyte(input int k, input int seed);
    int t;
    t = k + seed;
    return t[7:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (nRst) begin
      if (frame_drop) drop_seen++;
      if (wrRAMEn) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %0d data %0h, want no write", wrRAMAddr, wrRAMData);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("ram_write", {14'd0, wrRAMAddr, wrRAMData}, {14'd0, cmp_e});
        end
        dut_ram[wrRAMAddr] = wrRAMData;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends EB 90 + n_pay payload bytes; the model decides the fate of the frame
  task automatic model_and_send(input int seed, input int n_pay);
    logic [9:0] base;
    logic       accept;
    base   = m_sel ? 10'd512 : 10'd0;
    accept = !m_full[m_sel];
    if (accept) begin
      exp_q.push_back({base + 10'd1, 8'h90});
      exp_q.push_back({base, 8'hEB});
      for (int k = 2; k < n_pay + 2; k++) exp_q.push_back({base + 10'(k), pbyte(k, seed)});
    end else begin
      exp_drops++;
    end
    send_byte(8'hEB);
    send_byte(8'h90);
    last_sync_drop = frame_drop;
    last_sync_wen  = wrRAMEn;
    last_sync_addr = wrRAMAddr;
    last_sync_data = wrRAMData;
    for (int k = 2; k < n_pay + 2; k++) send_byte(pbyte(k, seed));
    if (accept && n_pay == 260) begin
      m_full[m_sel] = 1'b1;
      m_sel         = ~m_sel;
    end
  endtask

  task automatic check_flags(input string name);
    chk(name, {30'd0, UlRAM_wr_state}, {30'd0, m_full});
  endtask

  // Reader releases buffers in mask for six cycles
  task automatic rd_release(input logic [1:0] mask);
    @(negedge clk);
    UlRAM_rd_state = mask;
    repeat (6) @(negedge clk);
    UlRAM_rd_state = 2'b00;
    @(negedge clk);
    m_full = m_full & ~mask;
    check_flags("wr_state_after_release");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    nRst            = 1'b0;
    UlDataRevEnable = 1'b0;
    rx_data         = 8'h00;
    rx_valid        = 1'b0;
    UlRAM_rd_state  = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_wr_state",   {30'd0, UlRAM_wr_state}, 32'd0);
    chk("reset_wrRAMEn",    {31'd0, wrRAMEn}, 32'd0);
    chk("reset_wrRAMAddr",  {22'd0, wrRAMAddr}, 32'd0);
    chk("reset_wrRAMData",  {24'd0, wrRAMData}, 32'd0);
    chk("reset_frame_drop", {31'd0, frame_drop}, 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    UlDataRevEnable = 1'b1;
    @(negedge clk);

    // Clean frame into RAM0, then RAM1
    model_and_send(0, 260);
    chk("f1_first_write_addr", {22'd0, last_sync_addr}, 32'd1);
    chk("f1_first_write_data", {24'd0, last_sync_data}, 32'h90);
    chk("f1_wr_state_before_done", {30'd0, UlRAM_wr_state}, 32'd0);
    @(negedge clk);
    chk("f1_wr_state", {30'd0, UlRAM_wr_state}, 32'd1);
    chk("ram0_0",   {24'd0, dut_ram[0]},   32'hEB);
    chk("ram0_1",   {24'd0, dut_ram[1]},   32'h90);
    chk("ram0_2",   {24'd0, dut_ram[2]},   32'h02);
    chk("ram0_261", {24'd0, dut_ram[261]}, 32'h05);
    model_and_send(8'h40, 260);
    @(negedge clk);
    chk("f2_wr_state", {30'd0, UlRAM_wr_state}, 32'd3);
    chk("ram1_512", {24'd0, dut_ram[512]}, 32'hEB);
    chk("ram1_773", {24'd0, dut_ram[773]}, 32'h45);

    // Reader frees RAM0; next frame must land in RAM0
    rd_release(2'b01);
    chk("hs_wr_state", {30'd0, UlRAM_wr_state}, 32'd2);
    model_and_send(8'h11, 260);
    chk("f3_sync_addr", {22'd0, last_sync_addr}, 32'd1);
    @(negedge clk);
    chk("f3_wr_state", {30'd0, UlRAM_wr_state}, 32'd3);
    chk("ram0_2_f3", {24'd0, dut_ram[2]}, 32'h13);

    // Both buffers full: whole frame is discarded
    model_and_send(8'h22, 260);
    chk("busy_drop_at_sync", {31'd0, last_sync_drop}, 32'd1);
    chk("busy_no_write", {31'd0, last_sync_wen}, 32'd0);
    @(negedge clk);
    chk("busy_wr_state", {30'd0, UlRAM_wr_state}, 32'd3);
    chk("busy_drop_count", drop_seen, 32'd1);
    rd_release(2'b10);
    model_and_send(8'h33, 260);
    chk("after_busy_sync_addr", {22'd0, last_sync_addr}, 32'd513);
    @(negedge clk);
    check_flags("after_busy_flags");
    rd_release(2'b11);

    // Timeout: EB 90 + 100 bytes then silence
    model_and_send(8'h55, 100);
    repeat (4095) @(negedge clk);
    chk("timeout_not_yet", {31'd0, frame_drop}, 32'd0);
    @(negedge clk);
    chk("timeout_drop", {31'd0, frame_drop}, 32'd1);
    exp_drops++;
    @(negedge clk);
    chk("timeout_drop_count", drop_seen, 32'd2);
    chk("timeout_wr_state", {30'd0, UlRAM_wr_state}, 32'd0);
    model_and_send(8'h66, 260);
    chk("after_timeout_sync_addr", {22'd0, last_sync_addr}, 32'd1);
    @(negedge clk);
    chk("after_timeout_wr_state", {30'd0, UlRAM_wr_state}, 32'd1);
    chk("ram0_101_f7", {24'd0, dut_ram[101]}, 32'hCB);

    // False sync candidates before the real one
    send_byte(8'hEB);
    send_byte(8'h00);
    send_byte(8'h90);
    chk("false_sync_no_write", {31'd0, wrRAMEn}, 32'd0);
    send_byte(8'hEB);
    model_and_send(8'h77, 260);
    chk("false_sync_first_wen",  {31'd0, last_sync_wen}, 32'd1);
    chk("false_sync_first_addr", {22'd0, last_sync_addr}, 32'd513);
    chk("false_sync_first_data", {24'd0, last_sync_data}, 32'h90);
    @(negedge clk);
    chk("false_sync_wr_state", {30'd0, UlRAM_wr_state}, 32'd3);
    rd_release(2'b11);

    // Mid-frame disable while RAM0 is full and RAM1 is being written
    model_and_send(8'h88, 260);
    @(negedge clk);
    chk("pre_disable_wr_state", {30'd0, UlRAM_wr_state}, 32'd1);
    model_and_send(8'h99, 48);
    UlDataRevEnable = 1'b0;
    @(negedge clk);
    chk("disable_wr_state", {30'd0, UlRAM_wr_state}, 32'd0);
    chk("disable_wrRAMEn",  {31'd0, wrRAMEn}, 32'd0);
    chk("disable_no_drop",  {31'd0, frame_drop}, 32'd0);
    repeat (5) @(negedge clk);
    chk("disable_drop_count", drop_seen, 32'd2);
`ifdef UL_WR_OVF_CNT_EN
    chk("disable_ovf_count", {16'd0, ovf_count}, 32'd0);
`endif
    m_sel  = 1'b0;
    m_full = 2'b00;
    UlDataRevEnable = 1'b1;
    @(negedge clk);
    model_and_send(8'hAA, 260);
    chk("reenable_sync_addr", {22'd0, last_sync_addr}, 32'd1);
    @(negedge clk);
    check_flags("reenable_flags");
    chk("ram0_0_final", {24'd0, dut_ram[0]}, 32'hEB);

    // Final report
    repeat (3) @(negedge clk);
    chk("all_writes_seen", exp_q.size(), 32'd0);
    chk("total_drops", drop_seen, exp_drops);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
